// File: rtl/uart_tx.sv
// UART transmitter: bus-written bytes go through a small FIFO and are sent as
// 8N1 frames, 16 baud ticks per bit, tick interval = period+1 clocks.
module uart_tx #(
  parameter logic [7:0] PERIOD = 8'h1A,
  parameter int         DEPTH  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wren,
  input  logic       rden,
  input  logic [2:0] addr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       txout
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;

  state_t      state_q;
  logic [7:0]  period_q;
  logic        txen_q, ovf_q;
  logic [7:0]  mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0] cnt_q, cnt_d;
  logic [7:0]  baud_q;
  logic [3:0]  bt_q, bc_q;
  logic [9:0]  shift_q;
  logic        txout_q;

  logic wr_tx, full, empty, push, pop, tick, busy;

  assign wr_tx = wren && (addr == 3'b110);
  assign full  = (cnt_q == CNT_FULL);
  assign empty = (cnt_q == '0);
  // Fullness is sampled before any same-cycle pop, so a push racing a LOAD drops.
  assign push  = wr_tx && !full;
  assign pop   = (state_q == LOAD);
  // >= lets a lowered period take effect at once instead of wrapping the counter.
  assign tick  = (state_q == SEND) && (baud_q >= period_q);
  assign busy  = (state_q != IDLE);
  assign txout = txout_q;

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wp_q <= wp_q + PTR_ONE;
      if (pop)  rp_q <= rp_q + PTR_ONE;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      period_q <= PERIOD;
      txen_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (wren) begin
      case (addr)
        3'b100: period_q <= din;
        3'b110: if (full) ovf_q <= 1'b1;
        3'b111: begin
          txen_q <= din[0];
          if (din[2] || !din[0]) ovf_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      txout_q <= 1'b1;
      shift_q <= '1;
      baud_q  <= '0;
      bt_q    <= '0;
      bc_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          txout_q <= 1'b1;
          baud_q  <= '0;
          if (txen_q && !empty) state_q <= LOAD;
        end
        LOAD: begin
          shift_q <= {1'b1, mem_q[rp_q], 1'b0};
          bt_q    <= '0;
          bc_q    <= '0;
          baud_q  <= '0;
          state_q <= SEND;
        end
        SEND: begin
          txout_q <= shift_q[0];
          if (tick) begin
            baud_q <= '0;
            bt_q   <= bt_q + 4'd1;
            if (bt_q == 4'd15) begin
              shift_q <= {1'b1, shift_q[9:1]};
              bc_q    <= bc_q + 4'd1;
              if (bc_q == 4'd9) state_q <= IDLE;
            end
          end else begin
            baud_q <= baud_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    dout = 8'h00;
    if (rden) begin
      case (addr)
        3'b100:  dout = period_q;
        3'b111:  dout = {4'b0000, busy, ovf_q, ~full, txen_q};
        default: dout = 8'h00;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: frames are checked cycle by cycle against
// hand-built bit patterns; register reads against hand-computed values.
module tb_uart_tx;
  logic       clk = 1'b0;
  logic       reset, wren, rden;
  logic [2:0] addr;
  logic [7:0] din, dout;
  logic       txout;

  int nvec = 0;
  int nerr = 0;

  uart_tx #(.PERIOD(8'h1A), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .wren(wren), .rden(rden), .addr(addr),
    .din(din), .dout(dout), .txout(txout)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // All tasks are entered at a falling edge; writes land on the next rising edge.
  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    addr = a; din = d; wren = 1'b1;
    @(negedge clk);
    wren = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [7:0] v);
    addr = a; rden = 1'b1;
    #1 v = dout;
    rden = 1'b0;
  endtask

  task automatic wait_start(output int lat);
    bit found = 0;
    lat = 0;
    while (!found && lat < 2000) begin
      @(negedge clk);
      lat++;
      if (txout === 1'b0) found = 1;
    end
    chk("start_found", 32'(found), 32'd1);
  endtask

  // Called on the first sample of the start bit; ends on the last stop-bit sample.
  task automatic frame(input string tag, input logic [7:0] d, input int bc, input int drop_idx);
    logic [9:0] f;
    int bad = 0;
    f = {1'b1, d, 1'b0};
    for (int i = 0; i < 10*bc; i++) begin
      if (i > 0) @(negedge clk);
      if (i == drop_idx) begin addr = 3'b111; din = 8'h00; wren = 1'b1; end
      else wren = 1'b0;
      if (txout !== f[i/bc]) bad++;
    end
    wren = 1'b0;
    chk(tag, 32'(bad), 32'd0);
  endtask

  task automatic gap(output int g);
    g = 0;
    while (g < 100) begin
      @(negedge clk);
      if (txout === 1'b0) break;
      g++;
    end
  endtask

  task automatic quiet(input int n, output int lows);
    lows = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (txout !== 1'b1) lows++;
    end
  endtask

  initial begin
    logic [7:0] v;
    int lat, g, lows;
    int runs [9];
    int r, len, guard;
    logic prev;
    bit wrote;

    reset = 1'b1; wren = 1'b0; rden = 1'b0; addr = 3'b000; din = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst_txout", 32'(txout), 32'd1);
    rd(3'b111, v); chk("rst_ctrl", 32'(v), 32'h02);
    rd(3'b100, v); chk("rst_period", 32'(v), 32'h1A);
    rd(3'b110, v); chk("rst_txreg", 32'(v), 32'h00);
    rd(3'b000, v); chk("rst_unmapped", 32'(v), 32'h00);

    // Single frame at period 0: 16 clocks per bit
    wr(3'b100, 8'h00);
    wr(3'b111, 8'h01);
    wr(3'b110, 8'hA5);
    wait_start(lat);
    chk("start_latency", 32'(lat), 32'd3);
    rd(3'b111, v); chk("busy_midframe", 32'(v), 32'h0B);
    frame("frame_A5", 8'hA5, 16, -1);
    repeat (2) @(negedge clk);
    chk("idle_txout", 32'(txout), 32'd1);
    rd(3'b111, v); chk("busy_clear", 32'(v), 32'h03);

    // FIFO fill and overflow with TXEN off
    wr(3'b111, 8'h00);
    for (int i = 1; i <= 4; i++) wr(3'b110, 8'(i));
    rd(3'b111, v); chk("full_txrdy0", 32'(v), 32'h00);
    wr(3'b110, 8'h05);
    rd(3'b111, v); chk("overflow_set", 32'(v), 32'h04);
    wr(3'b111, 8'h01);
    rd(3'b111, v); chk("ovf_kept_en", 32'(v), 32'h05);
    wait_start(lat);
    frame("fifo_b1", 8'h01, 16, -1);
    gap(g); chk("gap_1_2", 32'(g), 32'd2);
    frame("fifo_b2", 8'h02, 16, -1);
    gap(g); chk("gap_2_3", 32'(g), 32'd2);
    frame("fifo_b3", 8'h03, 16, -1);
    gap(g); chk("gap_3_4", 32'(g), 32'd2);
    frame("fifo_b4", 8'h04, 16, -1);
    quiet(200, lows); chk("no_5th_byte", 32'(lows), 32'd0);
    wr(3'b111, 8'h05);
    rd(3'b111, v); chk("ovf_cleared", 32'(v), 32'h03);

    // TXEN dropped during the third data bit of the first byte
    wr(3'b110, 8'h11);
    wr(3'b110, 8'h22);
    wait_start(lat);
    frame("drop_b1", 8'h11, 16, 3*16 + 8);
    quiet(200, lows); chk("drop_no_b2", 32'(lows), 32'd0);
    rd(3'b111, v); chk("drop_ctrl", 32'(v), 32'h02);
    wr(3'b111, 8'h01);
    wait_start(lat);
    frame("drop_b2_resumed", 8'h22, 16, -1);

    // Period change mid-frame: 3 -> 1 during bit 5 of an alternating pattern
    quiet(4, lows);
    wr(3'b100, 8'h03);
    wr(3'b110, 8'h55);
    wait_start(lat);
    for (int i = 0; i < 9; i++) runs[i] = 0;
    r = 0; len = 1; prev = 1'b0; wrote = 0; guard = 0;
    while (r < 9 && guard < 3000) begin
      @(negedge clk);
      guard++;
      wren = 1'b0;
      if (r == 5 && len == 20 && !wrote) begin
        addr = 3'b100; din = 8'h01; wren = 1'b1; wrote = 1;
      end
      if (txout === prev) len++;
      else begin runs[r] = len; r++; len = 1; prev = txout; end
    end
    wren = 1'b0;
    for (int i = 0; i < 5; i++) chk($sformatf("bit%0d_p3", i), 32'(runs[i]), 32'd64);
    chk("bit5_no_stall", 32'(runs[5] > 32 && runs[5] <= 64), 32'd1);
    for (int i = 6; i < 9; i++) chk($sformatf("bit%0d_p1", i), 32'(runs[i]), 32'd32);
    quiet(100, lows);

    // Reset during bit 4 with a second byte still queued
    wr(3'b110, 8'hA5);
    wr(3'b110, 8'h3C);
    wait_start(lat);
    repeat (4*32 + 10) @(negedge clk);
    chk("pre_reset_low", 32'(txout), 32'd0);
    reset = 1'b1;
    #1 chk("reset_txout_async", 32'(txout), 32'd1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    rd(3'b111, v); chk("post_reset_ctrl", 32'(v), 32'h02);
    rd(3'b100, v); chk("post_reset_period", 32'(v), 32'h1A);
    wr(3'b111, 8'h01);
    quiet(300, lows); chk("post_reset_fifo_empty", 32'(lows), 32'd0);
    rd(3'b111, v); chk("post_reset_idle", 32'(v), 32'h03);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/uart_tx.md
# uart_tx

Register-mapped UART transmitter: the outbound counterpart of the UART receiver on the same CPU bus. Software writes bytes into a 4-entry transmit FIFO; the block serialises each as a 10-bit frame (start 0, 8 data bits LSB first, stop 1) on `txout`. It uses the same 8-bit baud-period register and 16-ticks-per-bit convention as the receiver, so the two link at the same rate.

## Interface
- `PERIOD`, 8'h1A, reset value of the baud-period register.
- `DEPTH`, 4, transmit FIFO depth in bytes (power of two).
- `clk`  in  1  clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-high.
- `wren`  in  1  bus write strobe, one cycle per access.
- `rden`  in  1  bus read strobe.
- `addr`  in  3  register select: 3'b100 period, 3'b110 tx_reg, 3'b111 control; other addresses ignored.
- `din`  in  8  write data.
- `dout`  out  8  read data, combinational.
- `txout`  out  1  serial line, registered, idles high.

## Operation
- Period register (3'b100): R/W, reset `PERIOD`.
- tx_reg (3'b110): write-only; write pushes `din` into FIFO if not full. Reads return 0.
- Control (3'b111): bit0 TXEN (R/W, reset 0); bit1 TXRDY = FIFO not full (RO); bit2 OVERFLOW (sticky; set by a tx_reg write while full; cleared by writing control with din[2]=1 or by TXEN=0); bit3 BUSY = FSM not in IDLE (RO); bits 7:4 read 0.
- `dout` = selected register when `rden`, else 8'h00. Reads have no side effects.
- Baud divider: 8-bit counter, held at 0 outside SEND; in SEND, increments each clock; when counter >= period, it asserts `tick` for one cycle and reloads 0. Tick interval = period+1 clocks; `>=` makes a mid-frame lowering of period take effect without a 256-clock wrap.
- FSM:
  - IDLE: `txout`=1. If TXEN and FIFO not empty, go to LOAD.
  - LOAD (1 cycle): pop FIFO; shift <= {1, data, 0}; bittimer (4-bit) and bitcount (4-bit) <= 0; go to SEND.
  - SEND: `txout` <= shift[0]. On each tick, increment bittimer; on a tick at bittimer==15, shift right filling 1 and bitcount++. Return to IDLE when bitcount reaches 10.
- TXEN cleared mid-frame: the current frame finishes and no new frame starts. FIFO contents are retained.
- Push while full: data is dropped, OVERFLOW is set, and the FIFO is unchanged. Fullness is taken before any same-cycle pop, so a push coinciding with a LOAD pop on a full FIFO is dropped.
- Push while empty, same cycle as IDLE check: the new byte is seen the next cycle.
- Reset at any time: FSM -> IDLE, `txout`=1, FIFO emptied, control=0, period=`PERIOD`, counters 0. A partial frame is abandoned.

## Timing
- Bit time = 16×(period+1) clocks. Default 26 gives 432 clocks/bit and 4320 clocks/frame.
- Write at edge N to tx_reg with TXEN=1 and idle FSM:
  - FIFO non-empty after edge N.
  - LOAD at N+1.
  - SEND from N+2.
  - `txout` falls (start bit) after edge N+3 (registered output).
- Back-to-back frames: stop bit is a full bit time, then IDLE (1 cycle) + LOAD (1 cycle). Inter-frame gap beyond the stop bit is exactly 2 clocks.
- BUSY is high from LOAD through the last SEND cycle.
- TXRDY and OVERFLOW are visible on `dout` the cycle after the causing edge.

## Test plan
- Reset: `txout`=1; read control = 8'h02; read period = 8'h1A; read tx_reg = 8'h00.
- Single frame: write period=8'h00, control=8'h01, tx_reg=8'hA5. Require `txout` = 0,1,0,1,0,0,1,0,1,1 with each bit 16 clocks wide, then idle high; BUSY clears.
- FIFO fill/overflow: TXEN=0; write 5 bytes 8'h01..8'h05.
  - After 4 writes, TXRDY=0; 5th write sets OVERFLOW (control reads 8'h04).
  - Enable TXEN: exactly bytes 01..04 are sent back-to-back with 2-clock extra gaps.
  - Writing control 8'h05 clears OVERFLOW.
- TXEN drop mid-frame: queue 2 bytes, clear TXEN during the 3rd data bit of byte 1. Byte 1 completes, byte 2 is not sent, and it is sent after TXEN=1 again.
- Period change: period=8'h03 mid-frame, then 8'h01 during bit 5. Bits before the change are 64 clocks, bits after are 32 clocks, with no 256-clock stall.
- Reset mid-frame: assert reset during bit 4. `txout`=1 immediately, FIFO empty, and the FSM is in IDLE after release.
